// File: rtl/sd_char_stats.sv
// sd_char_stats: multi-channel byte statistics engine for the sd_file_reader
// output stream. Counts total bytes plus occurrences of up to NUM_CH match
// bytes (optional ASCII case folding), with one selectable count for display,
// sticky saturation flags and a sticky completion flag.
//
// Optional feature: define SD_CHAR_STATS_LINE_EN to add a newline (0x0A)
// counter readable at sel = NUM_CH+1, with its own top sat bit.
//
// Counter index map: 0 = total, k = channel k-1, NUM_CH+1 = lines (optional).
module sd_char_stats #(
  parameter int                  NUM_CH    = 4,
  parameter int                  CNT_W     = 16,
  parameter logic [8*NUM_CH-1:0] MATCH     = "etao",
  parameter bit                  CASE_FOLD = 1'b0,
`ifdef SD_CHAR_STATS_LINE_EN
  localparam int                 NCNT      = NUM_CH + 2,
`else
  localparam int                 NCNT      = NUM_CH + 1,
`endif
  localparam int                 SEL_W     = $clog2(NCNT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             outen,
  input  logic [7:0]       outbyte,
  input  logic             endFile,
  input  logic             clear,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] count_sel,
  output logic [NCNT-1:0]  sat,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             s1_valid;
  logic [7:0]       s1_byte;
  logic [NCNT-1:0]  inc;
  logic [CNT_W-1:0] cnt [NCNT];

  // Fold upper-case ASCII to lower-case when case folding is enabled.
  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_FOLD && (b >= 8'h41) && (b <= 8'h5A)) return b | 8'h20;
    return b;
  endfunction

  // Bytes are only taken outside DONE, and a coincident clear drops them.
  assign accept = outen && (state != DONE) && !clear;
  assign busy   = (state == COUNT);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from the values present before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: clear wins, endFile ends the file from IDLE or COUNT.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (endFile) state_nx = DONE;
                 else if (outen) state_nx = COUNT;
        COUNT:   if (endFile) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage 1: register the (folded) byte and its valid; clear flushes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_byte  <= 8'h00;
    end else begin
      s1_valid <= accept;
      s1_byte  <= fold(outbyte);
    end
  end

  // Stage 2 compare: one increment request per counter, all in parallel.
  always_comb begin
    inc    = '0;
    inc[0] = s1_valid;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i+1] = s1_valid && (s1_byte == fold(MATCH[8*i +: 8]));
    end
`ifdef SD_CHAR_STATS_LINE_EN
    inc[NUM_CH+1] = s1_valid && (s1_byte == 8'h0A);
`endif
  end

  // Stage 2 counters: saturate at max and flag the attempted overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it
      // takes the asynchronous reset like any other state.
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      sat <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      sat <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (inc[i]) begin
          if (cnt[i] == CNT_MAX) sat[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Completion flag lags the DONE state by one cycle so that the last
  // byte's count is already in the counters when it rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      done <= 1'b0;
    else if (clear) done <= 1'b0;
    else            done <= (state == DONE);
  end

  // Registered display mux; out-of-range selects read zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   count_sel <= '0;
    else if (clear)              count_sel <= '0;
    else if (int'(sel) < NCNT)   count_sel <= cnt[sel];
    else                         count_sel <= '0;
  end

endmodule

// File: tb/tb_sd_char_stats.sv
// Self-checking bench for sd_char_stats. Three instances share one input
// stream: default (CNT_W=16), case folding on, and CNT_W=8. A small model
// tracks expected counts; readouts push expected values to a scoreboard
// queue and pop them as each count_sel value appears.
module tb_sd_char_stats;

  localparam int NUM_CH = 4;
`ifdef SD_CHAR_STATS_LINE_EN
  localparam int NCNT     = NUM_CH + 2;
  localparam int LINE_EXP = 3;
`else
  localparam int NCNT     = NUM_CH + 1;
  localparam int LINE_EXP = 0;
`endif
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             outen = 1'b0;
  logic [7:0]       outbyte = 8'h00;
  logic             endFile = 1'b0;
  logic             clear = 1'b0;
  logic [SEL_W-1:0] sel = '0;

  logic [15:0]      cs0, cs1;
  logic [7:0]       cs2;
  logic [NCNT-1:0]  sat0, sat1, sat2;
  logic             busy0, busy1, busy2;
  logic             done0, done1, done2;

  always #5 clk = ~clk;

  sd_char_stats #(.NUM_CH(4), .CNT_W(16), .MATCH("etao"), .CASE_FOLD(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte), .endFile(endFile),
    .clear(clear), .sel(sel), .count_sel(cs0), .sat(sat0), .busy(busy0), .done(done0));

  sd_char_stats #(.NUM_CH(4), .CNT_W(16), .MATCH("etao"), .CASE_FOLD(1'b1)) u_fold (
    .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte), .endFile(endFile),
    .clear(clear), .sel(sel), .count_sel(cs1), .sat(sat1), .busy(busy1), .done(done1));

  sd_char_stats #(.NUM_CH(4), .CNT_W(8), .MATCH("etao"), .CASE_FOLD(1'b0)) u_sat (
    .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte), .endFile(endFile),
    .clear(clear), .sel(sel), .count_sel(cs2), .sat(sat2), .busy(busy2), .done(done2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_cnt [3][6];
  logic [5:0]  m_sat [3];
  bit          m_done;
  int unsigned m_max [3] = '{65535, 65535, 255};
  bit          m_cf  [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] match_v = "etao";

  function automatic logic [7:0] tfold(input logic [7:0] b, input bit cf);
    if (cf && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    return b;
  endfunction

  task automatic bump(input int d, input int k);
    if (m_cnt[d][k] == m_max[d]) m_sat[d][k] = 1'b1;
    else                         m_cnt[d][k]++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] mb;
    for (int d = 0; d < 3; d++) begin
      bump(d, 0);
      for (int i = 0; i < NUM_CH; i++) begin
        mb = match_v[8*i +: 8];
        if (tfold(b, m_cf[d]) == tfold(mb, m_cf[d])) bump(d, i + 1);
      end
      if (b == 8'h0A) bump(d, 5);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) m_cnt[d][k] = 0;
      m_sat[d] = '0;
    end
    m_done = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit eof);
    outen   = 1'b1;
    outbyte = b;
    endFile = eof;
    if (!m_done) model_byte(b);
    if (eof) m_done = 1'b1;
    tick();
    outen   = 1'b0;
    endFile = 1'b0;
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) drive_byte(s[i], 1'b0);
  endtask

  // endFile alone; done must be low one cycle later and high two cycles later.
  task automatic end_file(input string name);
    endFile = 1'b1;
    m_done  = 1'b1;
    tick();
    endFile = 1'b0;
    check({name, "_done_early"}, 32'(done0), 32'd0);
    check({name, "_busy_off"}, 32'(busy0), 32'd0);
    tick();
    check({name, "_done"}, 32'(done0), 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_reset();
    tick();
    clear = 1'b0;
    tick();
    check("clear_done", 32'(done0), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    int          d;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic readout(input string name);
    exp_t        e;
    logic [31:0] got;
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 3; d++) begin
        e.tag = $sformatf("%s_d%0d_sel%0d", name, d, s);
        e.d   = d;
        e.val = (s < NCNT) ? m_cnt[d][s] : 32'd0;
        sb_q.push_back(e);
      end
    end
    for (int s = 0; s < 8; s++) begin
      sel = SEL_W'(s);
      tick();
      for (int d = 0; d < 3; d++) begin
        e = sb_q.pop_front();
        case (e.d)
          0:       got = 32'(cs0);
          1:       got = 32'(cs1);
          default: got = 32'(cs2);
        endcase
        check(e.tag, got, e.val);
      end
    end
    sel = '0;
    check({name, "_sat_d0"}, 32'(sat0), 32'(m_sat[0][NCNT-1:0]));
    check({name, "_sat_d1"}, 32'(sat1), 32'(m_sat[1][NCNT-1:0]));
    check({name, "_sat_d2"}, 32'(sat2), 32'(m_sat[2][NCNT-1:0]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count_sel", 32'(cs0), 32'd0);
    rstn = 1'b1;
    tick();
    check("rst_sat", 32'(sat0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);

    // Basic stream.
    stream("tea oat");
    check("basic_busy", 32'(busy0), 32'd1);
    end_file("basic");
    tick();
    readout("basic");
    do_clear();

    // Case folding (instance 1 folds, instance 0 does not).
    stream("TtEe");
    end_file("fold");
    tick();
    readout("fold");
    do_clear();

    // Saturation on the 8-bit instance.
    repeat (300) drive_byte(8'h65, 1'b0);
    end_file("satur");
    tick();
    readout("satur");
    check("satur_bits_d2", 32'(sat2[NUM_CH:0]), 32'h11);
    check("satur_bits_d0", 32'(sat0), 32'd0);
    do_clear();
    check("satur_cleared", 32'(sat2), 32'd0);

    // outen and endFile together, then ignored bytes in DONE.
    drive_byte(8'h61, 1'b1);
    tick();
    check("sim_done", 32'(done0), 32'd1);
    check("sim_busy", 32'(busy0), 32'd0);
    repeat (5) drive_byte(8'h65, 1'b0);
    repeat (3) tick();
    readout("sim");

    // clear coincident with outen: byte dropped, everything zero, IDLE.
    outen   = 1'b1;
    outbyte = 8'h74;
    clear   = 1'b1;
    model_reset();
    tick();
    outen = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
    check("clr_done", 32'(done0), 32'd0);
    check("clr_busy", 32'(busy0), 32'd0);
    readout("clr");

    // Reset mid-stream.
    stream("eta");
    repeat (3) tick();
    check("prerst_total", 32'(cs0), m_cnt[0][0]);
    rstn = 1'b0;
    #1;
    check("rst_async_count_sel", 32'(cs0), 32'd0);
    check("rst_async_busy", 32'(busy0), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    tick();
    stream("oat");
    end_file("rstmid");
    tick();
    readout("rstmid");
    check("rstmid_total", m_cnt[0][0], 32'd3);
    do_clear();

    // Count latency: byte in cycle n appears on count_sel in cycle n+3.
    sel = '0;
    drive_byte(8'h61, 1'b0);
    check("lat_n1", 32'(cs0), 32'd0);
    tick();
    check("lat_n2", 32'(cs0), 32'd0);
    tick();
    check("lat_n3", 32'(cs0), 32'd1);

    // Line counter (or zero readback when the feature is absent).
    stream("\nb\n\n");
    end_file("line");
    tick();
    readout("line");
    sel = 3'd5;
    tick();
    check("line_sel5", 32'(cs0), 32'(LINE_EXP));
    sel = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
